ub_word_packer: RTL and testbench

Upstream feeder for the unified buffer. It accepts a write command (base address, word count) and a byte stream from the UART/host receive path. It packs every DATA_WIDTH/8 bytes into one DATA_WIDTH-bit word and issues each word to the unified buffer as a single-word write (count = 1), paced to the buffer's two-cycle write acceptance.

---
 rtl/tpu_pkg.sv | 16 +
 rtl/byte_word_assembler.sv | 38 +++
 rtl/ub_word_packer.sv | 122 ++++++++++++
 tb/tb_ub_word_packer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the unified-buffer feed path.
// The UART command decoder uses these too.
package tpu_pkg;

   localparam int unsigned UB_WORD_W      = 256;
   localparam int unsigned BYTES_PER_WORD = UB_WORD_W / 8;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StIssue,
      StSettle,
      StDone
   } packer_state_t;

endpackage

// File: rtl/byte_word_assembler.sv
// Inserts bytes LSB-first into a word register, tracks the byte index and
// flags when the byte being offered completes the word.
module byte_word_assembler #(
   parameter int unsigned DATA_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  take,
   input  logic [7:0]            byte_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_complete
);

   localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
   localparam int unsigned IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   logic [DATA_WIDTH-1:0] word_q;
   logic [IDX_W-1:0]      byte_idx_q;

   assign word          = word_q;
   assign word_complete = (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));

   // Bytes overwrite in place, so the previous word stays readable until the
   // first byte of the next word lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q     <= '0;
         byte_idx_q <= '0;
      end else if (clear) begin
         byte_idx_q <= '0;
      end else if (take) begin
         word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
         byte_idx_q <= word_complete ? '0 : byte_idx_q + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ub_word_packer.sv
// Packs a host byte stream into buffer words and issues each as a single-word
// write, with one settle cycle after every strobe.
module ub_word_packer
   import tpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UB_WORD_W,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH:0]   cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_count,
   input  logic                  abort,
   input  logic                  s_byte_valid,
   output logic                  s_byte_ready,
   input  logic [7:0]            s_byte_data,
   output logic                  ub_wr_en,
   output logic [ADDR_WIDTH:0]   ub_wr_addr,
   output logic [ADDR_WIDTH:0]   ub_wr_count,
   output logic [DATA_WIDTH-1:0] ub_wr_data,
   input  logic                  ub_wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_written
);

   localparam int unsigned AW1 = ADDR_WIDTH + 1;

   packer_state_t state_q, state_d;
   logic [ADDR_WIDTH:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0] count_q, count_d;
   logic [ADDR_WIDTH:0] ww_q, ww_d;
   logic [ADDR_WIDTH:0] wr_addr_q, wr_addr_d;
   logic                asm_clear, byte_take, word_complete, wr_en;

   byte_word_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_assembler (
      .clk           (clk),
      .rst           (rst),
      .clear         (asm_clear),
      .take          (byte_take),
      .byte_data     (s_byte_data),
      .word          (ub_wr_data),
      .word_complete (word_complete)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         count_q   <= '0;
         ww_q      <= '0;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         ww_q      <= ww_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      ww_d      = ww_q;
      wr_addr_d = wr_addr_q;
      asm_clear = 1'b0;
      byte_take = 1'b0;
      wr_en     = 1'b0;
      // Abort beats every other transition; IDLE has nothing to cancel.
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  addr_d    = cmd_addr;
                  count_d   = cmd_count;
                  ww_d      = '0;
                  asm_clear = 1'b1;
                  state_d   = (cmd_count == '0) ? StDone : StFill;
               end
            end
            StFill: begin
               if (s_byte_valid) begin
                  byte_take = 1'b1;
                  if (word_complete) begin
                     wr_addr_d = addr_q;
                     state_d   = StIssue;
                  end
               end
            end
            StIssue: begin
               if (ub_wr_ready) begin
                  wr_en   = 1'b1;
                  addr_d  = addr_q + AW1'(1);
                  ww_d    = ww_q + AW1'(1);
                  state_d = StSettle;
               end
            end
            StSettle: state_d = (ww_q == count_q) ? StDone : StFill;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   assign cmd_ready     = (state_q == StIdle);
   assign s_byte_ready  = (state_q == StFill) && !abort;
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign ub_wr_en      = wr_en;
   assign ub_wr_addr    = wr_addr_q;
   assign ub_wr_count   = AW1'(1);
   assign words_written = ww_q;

endmodule

// File: tb/tb_ub_word_packer.sv
// Directed bench for ub_word_packer: single word, wrap burst, backpressure,
// gappy input, abort, zero count and reset in FILL.
module tb_ub_word_packer;

   localparam int unsigned DW = 256;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW:0]   cmd_addr;
   logic [AW:0]   cmd_count;
   logic          abort;
   logic          s_byte_valid;
   logic          s_byte_ready;
   logic [7:0]    s_byte_data;
   logic          ub_wr_en;
   logic [AW:0]   ub_wr_addr;
   logic [AW:0]   ub_wr_count;
   logic [DW-1:0] ub_wr_data;
   logic          ub_wr_ready;
   logic          busy;
   logic          done;
   logic [AW:0]   words_written;

   int n_checks = 0;
   int n_fails  = 0;

   int cyc = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int last_en_cyc = -1000;
   int min_gap = 100000;

   always #5 clk = ~clk;

   ub_word_packer #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_count     (cmd_count),
      .abort         (abort),
      .s_byte_valid  (s_byte_valid),
      .s_byte_ready  (s_byte_ready),
      .s_byte_data   (s_byte_data),
      .ub_wr_en      (ub_wr_en),
      .ub_wr_addr    (ub_wr_addr),
      .ub_wr_count   (ub_wr_count),
      .ub_wr_data    (ub_wr_data),
      .ub_wr_ready   (ub_wr_ready),
      .busy          (busy),
      .done          (done),
      .words_written (words_written)
   );

   // Strobe and done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (ub_wr_en) begin
         if (cyc - last_en_cyc < min_gap) min_gap = cyc - last_en_cyc;
         last_en_cyc = cyc;
         wr_cnt = wr_cnt + 1;
      end
      if (done) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input logic [7:0] base);
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 8; i++) w[8*i +: 8] = base + 8'(i);
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [AW:0] a, input logic [AW:0] n);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_count = n;
      #1;
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
   endtask

   // Returns at the cycle after the last accepted byte.
   task automatic send_bytes(input int n, input logic [7:0] first, input int gap_pct);
      int sent;
      int guard;
      sent  = 0;
      guard = 0;
      while (sent < n && guard < 4000) begin
         s_byte_valid = ($urandom_range(99) >= gap_pct);
         s_byte_data  = first + 8'(sent);
         #1;
         if (s_byte_valid && s_byte_ready) sent++;
         @(posedge clk);
         #1;
         guard++;
      end
      s_byte_valid = 1'b0;
      if (sent != n) chk("send_timeout", 256'(sent), 256'(n));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      chk({tag, "_s_byte_ready"}, s_byte_ready, 1'b0);
      chk({tag, "_wr_en"}, ub_wr_en, 1'b0);
      chk({tag, "_wr_addr"}, ub_wr_addr, 9'h000);
      chk({tag, "_wr_count"}, ub_wr_count, 9'h001);
      chk({tag, "_wr_data"}, ub_wr_data, '0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_words_written"}, words_written, 9'h000);
   endtask

   initial begin
      int            wr0;
      int            dn0;
      logic [AW:0]   ea;
      logic [DW-1:0] held;

      rst          = 1'b1;
      cmd_valid    = 1'b0;
      cmd_addr     = '0;
      cmd_count    = '0;
      abort        = 1'b0;
      s_byte_valid = 1'b0;
      s_byte_data  = '0;
      ub_wr_ready  = 1'b1;
      repeat (3) step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Single word at 0x005
      wr0 = wr_cnt;
      issue_cmd(9'h005, 9'd1);
      chk("single_fill_ready", s_byte_ready, 1'b1);
      send_bytes(32, 8'h00, 0);
      chk("single_wr_en", ub_wr_en, 1'b1);
      chk("single_wr_addr", ub_wr_addr, 9'h005);
      chk("single_wr_count", ub_wr_count, 9'h001);
      chk("single_wr_data", ub_wr_data,
          256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
      step();
      chk("single_settle_en", ub_wr_en, 1'b0);
      step();
      chk("single_done", done, 1'b1);
      step();
      chk("single_done_pulse", done, 1'b0);
      chk("single_words_written", words_written, 9'd1);
      chk("single_one_strobe", 256'(wr_cnt - wr0), 256'd1);

      // Burst of three with address wrap
      min_gap = 100000;
      last_en_cyc = -1000;
      wr0 = wr_cnt;
      issue_cmd(9'h1FF, 9'd3);
      for (int w = 0; w < 3; w++) begin
         send_bytes(32, 8'h40 + 8'(32 * w), 0);
         ea = 9'h1FF + 9'(w);
         chk("burst_wr_en", ub_wr_en, 1'b1);
         chk("burst_wr_addr", ub_wr_addr, ea);
         chk("burst_wr_data", ub_wr_data, exp_word(8'h40 + 8'(32 * w)));
         step();
      end
      step();
      chk("burst_done", done, 1'b1);
      chk("burst_words_written", words_written, 9'd3);
      chk("burst_gap_ge_34", 256'(min_gap >= 34), 256'd1);
      chk("burst_strobes", 256'(wr_cnt - wr0), 256'd3);
      step();

      // Backpressure in ISSUE
      ub_wr_ready = 1'b0;
      wr0 = wr_cnt;
      issue_cmd(9'h010, 9'd1);
      send_bytes(32, 8'h60, 0);
      held = ub_wr_data;
      chk("bp_data_packed", held, exp_word(8'h60));
      s_byte_valid = 1'b1;
      s_byte_data  = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_wr_en_low", ub_wr_en, 1'b0);
         chk("bp_byte_ready_low", s_byte_ready, 1'b0);
         step();
      end
      s_byte_valid = 1'b0;
      ub_wr_ready  = 1'b1;
      #1;
      chk("bp_strobe", ub_wr_en, 1'b1);
      chk("bp_data_held", ub_wr_data, held);
      chk("bp_addr", ub_wr_addr, 9'h010);
      step();
      step();
      chk("bp_done", done, 1'b1);
      chk("bp_strobes", 256'(wr_cnt - wr0), 256'd1);
      step();

      // Gappy input, 30% idle
      issue_cmd(9'h020, 9'd2);
      send_bytes(32, 8'h00, 30);
      chk("gappy_w0_data", ub_wr_data, exp_word(8'h00));
      chk("gappy_w0_addr", ub_wr_addr, 9'h020);
      step();
      step();
      send_bytes(32, 8'h20, 30);
      chk("gappy_w1_data", ub_wr_data, exp_word(8'h20));
      chk("gappy_w1_addr", ub_wr_addr, 9'h021);
      step();
      step();
      chk("gappy_done", done, 1'b1);
      step();

      // Abort after 10 bytes of word 2
      issue_cmd(9'h030, 9'd4);
      send_bytes(32, 8'h80, 0);
      step();
      step();
      send_bytes(10, 8'hA0, 0);
      wr0 = wr_cnt;
      dn0 = done_cnt;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_idle", cmd_ready, 1'b1);
      chk("abort_not_busy", busy, 1'b0);
      chk("abort_words_written", words_written, 9'd1);
      s_byte_valid = 1'b1;
      repeat (40) step();
      s_byte_valid = 1'b0;
      chk("abort_no_strobe", 256'(wr_cnt - wr0), 256'd0);
      chk("abort_no_done", 256'(done_cnt - dn0), 256'd0);
      issue_cmd(9'h040, 9'd1);
      send_bytes(32, 8'hC0, 0);
      chk("post_abort_data", ub_wr_data, exp_word(8'hC0));
      chk("post_abort_addr", ub_wr_addr, 9'h040);
      step();
      step();
      chk("post_abort_done", done, 1'b1);
      chk("post_abort_words", words_written, 9'd1);
      step();

      // Zero count
      wr0 = wr_cnt;
      issue_cmd(9'h050, 9'd0);
      chk("zero_done", done, 1'b1);
      step();
      chk("zero_done_pulse", done, 1'b0);
      chk("zero_words_written", words_written, 9'd0);
      chk("zero_no_strobe", 256'(wr_cnt - wr0), 256'd0);

      // Reset during FILL
      issue_cmd(9'h060, 9'd1);
      send_bytes(5, 8'h11, 0);
      rst = 1'b1;
      step();
      check_reset_outputs("rst_fill");
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
